// File: rtl/ka_pkg.sv
// rtl/ka_pkg.sv - shared Karatsuba sub-operand indices, splitter states and width helper
package ka_pkg;

    localparam logic [1:0] KA_IDX_LO  = 2'd0;
    localparam logic [1:0] KA_IDX_MID = 2'd1;
    localparam logic [1:0] KA_IDX_HI  = 2'd2;

    typedef enum logic [1:0] {
        KA_IDLE     = 2'd0,
        KA_EMIT_LO  = 2'd1,
        KA_EMIT_MID = 2'd2,
        KA_EMIT_HI  = 2'd3
    } ka_state_t;

    function automatic int ka_half_width(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/ka_operand_splitter_if.sv
// rtl/ka_operand_splitter_if.sv - operand-in / sub-operand-out handshake bundle of the splitter
interface ka_operand_splitter_if #(
    parameter int N = 93
);
    import ka_pkg::*;

    localparam int H = ka_half_width(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [H-1:0] out_a;
    logic [H-1:0] out_b;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_idx, out_last, busy
    );

endinterface

// File: rtl/ka_split_halves.sv
// rtl/ka_split_halves.sv - split an N-bit GF(2) polynomial into low, high and low^high halves
module ka_split_halves
    import ka_pkg::*;
#(
    parameter int N = 93
) (
    input  logic [N-1:0]                  x,
    output logic [ka_half_width(N)-1:0]   x_lo,
    output logic [ka_half_width(N)-1:0]   x_hi,
    output logic [ka_half_width(N)-1:0]   x_mid
);

    localparam int H = ka_half_width(N);
    localparam int L = N - H;

    // High half is zero-extended to H bits; its top bit stays 0 for odd N.
    always_comb begin
        x_lo         = x[H-1:0];
        x_hi         = '0;
        x_hi[L-1:0]  = x[N-1:H];
        x_mid        = x_lo ^ x_hi;
    end

endmodule

// File: rtl/ka_operand_splitter.sv
// rtl/ka_operand_splitter.sv - issues (A0,B0), (A0^A1,B0^B1), (A1,B1) for one latched operand pair
module ka_operand_splitter
    import ka_pkg::*;
#(
    parameter int N = 93
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ka_operand_splitter_if.slave  bus
);

    localparam int H = ka_half_width(N);

    ka_state_t    state;
    ka_state_t    state_nx;
    logic         ready_en;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [H-1:0] a_lo, a_hi, a_mid;
    logic [H-1:0] b_lo, b_hi, b_mid;
    logic [H-1:0] out_a_q, out_b_q;
    logic [1:0]   out_idx_q;
    logic         out_last_q;
    logic [H-1:0] nx_a, nx_b;
    logic [1:0]   nx_idx;
    logic         accept;
    logic         handshake;
    logic         in_ready_c;
    logic         out_valid_c;

    ka_split_halves #(.N(N)) u_split_a (.x(a_q), .x_lo(a_lo), .x_hi(a_hi), .x_mid(a_mid));
    ka_split_halves #(.N(N)) u_split_b (.x(b_q), .x_lo(b_lo), .x_hi(b_hi), .x_mid(b_mid));

    assign accept    = bus.in_valid && in_ready_c;
    assign handshake = out_valid_c && bus.out_ready;

    // State register; ready_en keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= KA_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;
        end
    end

    // Next-state: advance one sub-pair per handshake, chaining straight into a new pair from EMIT_HI.
    always_comb begin
        state_nx = state;
        unique case (state)
            KA_IDLE:     if (accept)    state_nx = KA_EMIT_LO;
            KA_EMIT_LO:  if (handshake) state_nx = KA_EMIT_MID;
            KA_EMIT_MID: if (handshake) state_nx = KA_EMIT_HI;
            KA_EMIT_HI: begin
                if (accept)         state_nx = KA_EMIT_LO;
                else if (handshake) state_nx = KA_IDLE;
            end
            default:                state_nx = KA_IDLE;
        endcase
    end

    // FSM outputs; out_ready reaches in_ready only through the EMIT_HI term.
    always_comb begin
        out_valid_c = (state != KA_IDLE);
        in_ready_c  = ready_en && ((state == KA_IDLE) ||
                                   ((state == KA_EMIT_HI) && bus.out_ready));
    end

    // Select the sub-pair belonging to the state being entered; the low pair comes off the input directly.
    always_comb begin
        nx_a   = '0;
        nx_b   = '0;
        nx_idx = KA_IDX_LO;
        unique case (state_nx)
            KA_EMIT_LO: begin
                nx_a   = bus.in_a[H-1:0];
                nx_b   = bus.in_b[H-1:0];
                nx_idx = KA_IDX_LO;
            end
            KA_EMIT_MID: begin
                nx_a   = a_mid;
                nx_b   = b_mid;
                nx_idx = KA_IDX_MID;
            end
            KA_EMIT_HI: begin
                nx_a   = a_hi;
                nx_b   = b_hi;
                nx_idx = KA_IDX_HI;
            end
            default: begin
                nx_a   = '0;
                nx_b   = '0;
                nx_idx = KA_IDX_LO;
            end
        endcase
    end

    // Latch operands on accept and reload the output registers only when the state moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_idx_q  <= KA_IDX_LO;
            out_last_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            if (accept || handshake) begin
                out_a_q    <= nx_a;
                out_b_q    <= nx_b;
                out_idx_q  <= nx_idx;
                out_last_q <= (state_nx == KA_EMIT_HI);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = out_valid_c;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

endmodule
